seg_scan_mux: RTL and testbench



---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 25 ++
 rtl/seg_scan_mux.sv | 150 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment-display constants: segment bit positions and the BCD glyph codes
// built from them (bit0 = a ... bit6 = g, active-high).
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] M_A = 7'(1) << SEG_A;
    localparam logic [6:0] M_B = 7'(1) << SEG_B;
    localparam logic [6:0] M_C = 7'(1) << SEG_C;
    localparam logic [6:0] M_D = 7'(1) << SEG_D;
    localparam logic [6:0] M_E = 7'(1) << SEG_E;
    localparam logic [6:0] M_F = 7'(1) << SEG_F;
    localparam logic [6:0] M_G = 7'(1) << SEG_G;

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_0   = M_A | M_B | M_C | M_D | M_E | M_F;
    localparam logic [6:0] SEG_1   = M_B | M_C;
    localparam logic [6:0] SEG_2   = M_A | M_B | M_D | M_E | M_G;
    localparam logic [6:0] SEG_3   = M_A | M_B | M_C | M_D | M_G;
    localparam logic [6:0] SEG_4   = M_B | M_C | M_F | M_G;
    localparam logic [6:0] SEG_5   = M_A | M_C | M_D | M_F | M_G;
    localparam logic [6:0] SEG_6   = M_A | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG_7   = M_A | M_B | M_C;
    localparam logic [6:0] SEG_8   = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG_9   = M_A | M_B | M_C | M_D | M_F | M_G;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder; non-BCD codes 10..15 render dark.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-slot blanking gap and frame-aligned
// double buffering. Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [0:0]          state, state_next;
    logic                slot_end, frame_end;

    logic [4*DIGITS-1:0] shadow_bcd, active_bcd;
    logic [DIGITS-1:0]   shadow_dp, active_dp;
    logic                pending;

    logic [3:0]          cur_bcd;
    logic                cur_dp;
    logic [DIGITS-1:0]   cur_en;
    logic [6:0]          cur_seg;
    logic                lzb_blank;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        cnt_next  = slot_end ? '0 : cnt + CNT_W'(1);
        idx_next  = idx;
        if (slot_end) idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

        state_next = state;
        case (state)
            ST_BLANK: if (cnt_next >= CNT_SHOW) state_next = ST_SHOW;
            ST_SHOW:  if (slot_end)             state_next = ST_BLANK;
            default:                            state_next = ST_BLANK;
        endcase
    end

    // The slot index never changes on an edge entering SHOW, so the current idx
    // already names the digit that will be lit.
    always_comb begin
        cur_bcd = 4'd0;
        cur_dp  = 1'b0;
        cur_en  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_bcd   = active_bcd[4*i +: 4];
                cur_dp    = active_dp[i];
                cur_en[i] = 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic zero_run;

    // Walk down from the most significant digit; a digit is blanked while the run of zeros is unbroken.
    always_comb begin
        zero_run  = 1'b1;
        lzb_blank = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (active_bcd[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) lzb_blank = zero_run;
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= ST_BLANK;
            // NOTE: the digit buffers are ordinary flops, so they are reset along with the control state.
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            active_bcd <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            seg_out    <= SEG_OFF;
            dp_out     <= 1'b0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            idx        <= idx_next;
            state      <= state_next;
            frame_done <= frame_end;

            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end

            // A load coinciding with the frame boundary goes straight to the active copy.
            if (load && frame_end) begin
                active_bcd <= bcd_in;
                active_dp  <= dp_in;
                pending    <= 1'b0;
            end else if (load) begin
                pending    <= 1'b1;
            end else if (frame_end && pending) begin
                active_bcd <= shadow_bcd;
                active_dp  <= shadow_dp;
                pending    <= 1'b0;
            end

            if (state_next == ST_SHOW) begin
                dig_en  <= cur_en;
                seg_out <= lzb_blank ? SEG_OFF : cur_seg;
                dp_out  <= cur_dp;
            end else begin
                dig_en  <= '0;
                seg_out <= SEG_OFF;
                dp_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues the expected digit slots of each
// frame, a monitor pops one entry whenever a digit slot lights up and compares it.
`timescale 1ns/1ps
module tb_seg_scan_mux;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int SHOW_LEN  = SCAN_DIV - BLANK_CYC;
    localparam int FRAME_LEN = DIGITS * SCAN_DIV;

    localparam logic [6:0] S_OFF = 7'b0000000;
    localparam logic [6:0] S0    = 7'b0111111;
    localparam logic [6:0] S1    = 7'b0000110;
    localparam logic [6:0] S2    = 7'b1011011;
    localparam logic [6:0] S3    = 7'b1001111;
    localparam logic [6:0] S4    = 7'b1100110;
    localparam logic [6:0] S5    = 7'b1101101;
    localparam logic [6:0] S6    = 7'b1111101;
    localparam logic [6:0] S7    = 7'b0000111;
    localparam logic [6:0] S8    = 7'b1111111;
    localparam logic [6:0] S9    = 7'b1101111;

    // Glyph expected on a zero digit with only zeros above it.
`ifdef SEG_SCAN_LZB_EN
    localparam logic [6:0] Z_HI = S_OFF;
`else
    localparam logic [6:0] Z_HI = S0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    slot_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dp);
        slot_t e;
        e.en = 4'b0001; e.seg = s0; e.dp = dp[0]; sb_q.push_back(e);
        e.en = 4'b0010; e.seg = s1; e.dp = dp[1]; sb_q.push_back(e);
        e.en = 4'b0100; e.seg = s2; e.dp = dp[2]; sb_q.push_back(e);
        e.en = 4'b1000; e.seg = s3; e.dp = dp[3]; sb_q.push_back(e);
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: frame_done never pulsed", tag);
    endtask

    task automatic wait_en(input logic [3:0] target, input string tag);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            @(negedge clk);
            if (dig_en == target) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: dig_en never reached %b", tag, target);
    endtask

    task automatic pulse_load(input logic [15:0] bcd, input logic [3:0] dp);
        bcd_in = bcd;
        dp_in  = dp;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Monitor: samples on the falling edge, pops one expectation per lit slot.
    initial begin : monitor
        logic [3:0] prev_en;
        int         run, dark, cyc, last_fd;
        bit         have_slot, have_fd, exp_valid;
        slot_t      cur_exp;
        prev_en = '0; run = 0; dark = 0; cyc = 0; last_fd = 0;
        have_slot = 1'b0; have_fd = 1'b0; exp_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_en = '0; run = 0; dark = 0;
                have_slot = 1'b0; have_fd = 1'b0; exp_valid = 1'b0;
            end else begin
                check("dig_en one-hot", 32'($onehot0(dig_en)), 32'd1);
                if (frame_done) begin
                    if (have_fd) check("frame_done period", 32'(cyc - last_fd), 32'(FRAME_LEN));
                    last_fd = cyc;
                    have_fd = 1'b1;
                end
                if (dig_en == 4'b0000) begin
                    check("dark outputs", 32'({dp_out, seg_out}), 32'd0);
                    if (prev_en != 4'b0000) begin
                        check("show length", 32'(run), 32'(SHOW_LEN));
                        have_slot = 1'b1;
                        dark = 0;
                        exp_valid = 1'b0;
                    end
                    dark++;
                end else if (prev_en == 4'b0000) begin
                    if (have_slot) check("blank length", 32'(dark), 32'(BLANK_CYC));
                    run = 1;
                    if (sb_q.size() > 0) begin
                        cur_exp   = sb_q.pop_front();
                        exp_valid = 1'b1;
                        check("slot dig_en", 32'(dig_en), 32'(cur_exp.en));
                        check("slot seg_out", 32'(seg_out), 32'(cur_exp.seg));
                        check("slot dp_out", 32'(dp_out), 32'(cur_exp.dp));
                    end
                end else begin
                    run++;
                    if (exp_valid)
                        check("slot hold", 32'({dig_en, dp_out, seg_out}),
                              32'({cur_exp.en, cur_exp.dp, cur_exp.seg}));
                end
                prev_en = dig_en;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset seg_out", 32'(seg_out), 32'd0);
        check("reset dp_out", 32'(dp_out), 32'd0);
        check("reset dig_en", 32'(dig_en), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        push_frame(S0, Z_HI, Z_HI, Z_HI, 4'b0000);

        // Mid-frame load: current frame keeps zeros, next frame shows 1234.
        wait_en(4'b0010, "mid-frame slot");
        pulse_load(16'h1234, 4'b0100);
        wait_frame("frame after 1234 load");
        push_frame(S4, S3, S2, S1, 4'b0100);

        // Load exactly on the frame boundary cycle (cnt=7, idx=3): bypass.
        repeat (FRAME_LEN - 1) @(negedge clk);
        pulse_load(16'h5678, 4'b0000);
        check("bypass frame_done", 32'(frame_done), 32'd1);
        check("bypass pending", 32'(dut.pending), 32'd0);
        push_frame(S8, S7, S6, S5, 4'b0000);

        // Two loads in one frame: the later one wins.
        repeat (5) @(negedge clk);
        pulse_load(16'h1111, 4'b0000);
        repeat (10) @(negedge clk);
        pulse_load(16'h9999, 4'b0000);
        wait_frame("frame after 9999 load");
        push_frame(S9, S9, S9, S9, 4'b0000);

        // Non-BCD code A decodes dark while its dp is still driven.
        repeat (3) @(negedge clk);
        pulse_load(16'h00A7, 4'b0010);
        wait_frame("frame after 00A7 load");
        push_frame(S7, S_OFF, Z_HI, Z_HI, 4'b0010);

        // Leading zeros above a 7; dp on the top digit survives blanking.
        repeat (3) @(negedge clk);
        pulse_load(16'h0007, 4'b1000);
        wait_frame("frame after 0007 load");
        push_frame(S7, Z_HI, Z_HI, Z_HI, 4'b1000);

        // Leave a load pending, then reset while digit 2 is lit.
        repeat (3) @(negedge clk);
        pulse_load(16'h8888, 4'b1111);
        wait_en(4'b0100, "digit 2 before reset");
        #1 rst = 1'b1;
        #1;
        check("async reset seg_out", 32'(seg_out), 32'd0);
        check("async reset dp_out", 32'(dp_out), 32'd0);
        check("async reset dig_en", 32'(dig_en), 32'd0);
        check("async reset frame_done", 32'(frame_done), 32'd0);
        check("async reset pending", 32'(dut.pending), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_frame(S0, Z_HI, Z_HI, Z_HI, 4'b0000);
        wait_frame("first frame after reset");
        push_frame(S0, Z_HI, Z_HI, Z_HI, 4'b0000);

        for (int i = 0; i < 2 * FRAME_LEN && sb_q.size() > 0; i++) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        repeat (SCAN_DIV) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
